jtbubl_vtiming: RTL

//  Parametrised video timing generator for the jtbubl video path: derives pixel clock

---
 rtl/jtbubl_vtiming_pkg.sv | 26 ++
 rtl/jtbubl_vtiming_cen.sv | 34 +++
 rtl/jtbubl_vtiming.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/jtbubl_vtiming_pkg.sv
// Default bubl video timing constants and the V-range wrap helper shared by the timing block.
package jtbubl_vtiming_pkg;

  localparam int unsigned BUBL_CEN_DIV  = 8;
  localparam int unsigned BUBL_HW       = 9;
  localparam int unsigned BUBL_VW       = 9;
  localparam int unsigned BUBL_H_TOTAL  = 384;
  localparam int unsigned BUBL_HB_START = 255;
  localparam int unsigned BUBL_HB_END   = 383;
  localparam int unsigned BUBL_HS_START = 297;
  localparam int unsigned BUBL_HS_LEN   = 32;
  localparam int unsigned BUBL_V_START  = 16;
  localparam int unsigned BUBL_V_END    = 279;
  localparam int unsigned BUBL_VB_START = 240;
  localparam int unsigned BUBL_VB_END   = 279;
  localparam int unsigned BUBL_VS_START = 254;
  localparam int unsigned BUBL_VS_LEN   = 3;
  localparam int unsigned BUBL_IRQ_H    = 0;

  // Folds a line number that ran past v_end back to the top of the visible range.
  function automatic int unsigned vwrap(input int unsigned v, input int unsigned v_start,
                                        input int unsigned v_end);
    return (v > v_end) ? v_start + (v - v_end - 1) : v;
  endfunction

endpackage

// File: rtl/jtbubl_vtiming_cen.sv
// Pixel clock-enable divider: pxl_cen once per CEN_DIV clks, pxl2_cen twice, both registered.
module jtbubl_vtiming_cen #(
  parameter int unsigned CEN_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic pxl2_cen,
  output logic pxl_cen
);

  localparam int unsigned CW = $clog2(CEN_DIV);
  localparam logic [CW-1:0] CntLast = CW'(CEN_DIV - 1);
  localparam logic [CW-1:0] CntHalf = CW'(CEN_DIV / 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
  end

  // Enables are decoded from the next count so they are high while the counter sits at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pxl_cen  <= 1'b0;
      pxl2_cen <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pxl_cen  <= (cnt_d == '0);
      pxl2_cen <= (cnt_d == '0) || (cnt_d == CntHalf);
    end
  end

endmodule

// File: rtl/jtbubl_vtiming.sv
// Video timing generator: H/V counters, registered blank/sync/init decode and raster-line IRQ.
module jtbubl_vtiming
  import jtbubl_vtiming_pkg::*;
#(
  parameter int unsigned CEN_DIV  = BUBL_CEN_DIV,
  parameter int unsigned HW       = BUBL_HW,
  parameter int unsigned VW       = BUBL_VW,
  parameter int unsigned H_TOTAL  = BUBL_H_TOTAL,
  parameter int unsigned HB_START = BUBL_HB_START,
  parameter int unsigned HB_END   = BUBL_HB_END,
  parameter int unsigned HS_START = BUBL_HS_START,
  parameter int unsigned HS_LEN   = BUBL_HS_LEN,
  parameter int unsigned V_START  = BUBL_V_START,
  parameter int unsigned V_END    = BUBL_V_END,
  parameter int unsigned VB_START = BUBL_VB_START,
  parameter int unsigned VB_END   = BUBL_VB_END,
  parameter int unsigned VS_START = BUBL_VS_START,
  parameter int unsigned VS_LEN   = BUBL_VS_LEN,
  parameter int unsigned IRQ_H    = BUBL_IRQ_H
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pxl2_cen,
  output logic          pxl_cen,
  output logic [HW-1:0] hdump,
  output logic [VW-1:0] vdump,
  output logic [VW-1:0] vrender,
  output logic [VW-1:0] vrender1,
  output logic          Hinit,
  output logic          Vinit,
  output logic          LHBL,
  output logic          LVBL,
  output logic          HS,
  output logic          VS,
  input  logic          irq_en,
  input  logic [VW-1:0] irq_line,
  input  logic          irq_ack,
  output logic          irq_n
);

  localparam logic [HW-1:0] HLast  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VFirst = VW'(V_START);
  localparam logic [VW-1:0] VLast  = VW'(V_END);
  localparam logic [VW-1:0] VRInit = VW'(vwrap(V_START + 1, V_START, V_END));
  localparam logic [VW-1:0] VR1Init = VW'(vwrap(V_START + 2, V_START, V_END));
  localparam int unsigned   VLines = V_END - V_START + 1;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [VW-1:0] vr_q, vr_d;
  logic [VW-1:0] vr1_q, vr1_d;
  logic          hinit_q, hinit_d, vinit_q, vinit_d;
  logic          lhbl_q, lhbl_d, lvbl_q, lvbl_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          irq_n_q, irq_n_d, irq_trig;
  int unsigned   h, v, hs_off, vs_off;

  jtbubl_vtiming_cen #(
    .CEN_DIV (CEN_DIV)
  ) u_cen (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl2_cen (pxl2_cen),
    .pxl_cen  (pxl_cen)
  );

  // vrender/vrender1 run as their own counters so they always track vdump with no latency.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    vr_d   = vr_q;
    vr1_d  = vr1_q;
    if (pxl_cen) begin
      if (hcnt_q == HLast) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VLast) ? VFirst : vcnt_q + VW'(1);
        vr_d   = VW'(vwrap(32'(vr_q) + 1, V_START, V_END));
        vr1_d  = VW'(vwrap(32'(vr1_q) + 1, V_START, V_END));
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  always_comb begin
    h      = 32'(hcnt_q);
    v      = 32'(vcnt_q);
    hs_off = h + H_TOTAL - HS_START;
    if (hs_off >= H_TOTAL) hs_off = hs_off - H_TOTAL;
    vs_off = (v >= VS_START) ? v - VS_START : v + VLines - VS_START;

    hinit_d = (h == 0);
    vinit_d = (h == 0) && (v == V_START);
    lhbl_d  = !((h >= HB_START) && (h <= HB_END));
    hs_d    = (hs_off < HS_LEN);
    // LVBL and VS only move on their line-boundary pixel.
    lvbl_d  = lvbl_q;
    if (h == HB_START) lvbl_d = !((v >= VB_START) && (v <= VB_END));
    vs_d    = vs_q;
    if (h == HS_START) vs_d = (vs_off < VS_LEN);

    // A trigger coinciding with an ack wins.
    irq_trig = pxl_cen && irq_en && (vcnt_q == irq_line) && (h == IRQ_H);
    irq_n_d  = irq_n_q;
    if (irq_trig)     irq_n_d = 1'b0;
    else if (irq_ack) irq_n_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= VFirst;
      vr_q    <= VRInit;
      vr1_q   <= VR1Init;
      hinit_q <= 1'b0;
      vinit_q <= 1'b0;
      lhbl_q  <= 1'b0;
      lvbl_q  <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      vr_q    <= vr_d;
      vr1_q   <= vr1_d;
      irq_n_q <= irq_n_d;
      if (pxl_cen) begin
        hinit_q <= hinit_d;
        vinit_q <= vinit_d;
        lhbl_q  <= lhbl_d;
        lvbl_q  <= lvbl_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
      end
    end
  end

  assign hdump    = hcnt_q;
  assign vdump    = vcnt_q;
  assign vrender  = vr_q;
  assign vrender1 = vr1_q;
  assign Hinit    = hinit_q;
  assign Vinit    = vinit_q;
  assign LHBL     = lhbl_q;
  assign LVBL     = lvbl_q;
  assign HS       = hs_q;
  assign VS       = vs_q;
  assign irq_n    = irq_n_q;

endmodule
